// File: rtl/multiword_adder_sequencer.sv
// multiword_adder_sequencer: WORDS*WIDTH-bit add/sub by sequencing one shared WIDTH-bit adder, LS word first
module multiword_adder_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [WORDS*WIDTH-1:0]   a,
    input  logic [WORDS*WIDTH-1:0]   b,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [WORDS*WIDTH-1:0]   result,
    output logic                     cout,
    output logic                     ovf,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_c0,
    input  logic [WIDTH:0]           add_s
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, op_q, op_d, cout_q, cout_d, ovf_q, ovf_d;
    logic done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic [WORDS-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic msb_c;
    // Shared adder sees the current word pair only while running, zero otherwise
    always_comb begin
        add_a  = (state_q == RUN) ? a_q[idx_q] : '0;
        add_b  = (state_q == RUN) ? (b_q[idx_q] ^ {WIDTH{op_q}}) : '0;
        add_c0 = (state_q == RUN) & carry_q;
    end
    assign msb_c = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_s[WIDTH-1];
    // Sequencer next state: accept in IDLE, one word per cycle in RUN, one-cycle DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = b;
                op_d    = op_sub;
                carry_d = op_sub;
                idx_d   = '0;
                state_d = RUN;
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end
        end else if (state_q == RUN) begin
            res_d[idx_q] = add_s[WIDTH-1:0];
            carry_d      = add_s[WIDTH];
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST) begin
                cout_d  = add_s[WIDTH];
                ovf_d   = add_s[WIDTH] ^ msb_c;
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else begin
            state_d = IDLE;
            ready_d = 1'b1;
        end
    end
    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end
    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign ready  = ready_q;
endmodule
